// File: rtl/apb_regs_pkg.sv
// Shared definitions for the APB completer register block: register offsets,
// CTRL field positions and the transfer FSM state type.
package apb_regs_pkg;

  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] STATUS_OFF   = 8'h04;
  localparam logic [7:0] COUNT_OFF    = 8'h08;
  localparam logic [7:0] SCRATCH_BASE = 8'h10;

  // Word indices, matching the paddr[7:2] decode.
  localparam logic [5:0] CTRL_IDX    = CTRL_OFF[7:2];
  localparam logic [5:0] STATUS_IDX  = STATUS_OFF[7:2];
  localparam logic [5:0] COUNT_IDX   = COUNT_OFF[7:2];
  localparam logic [5:0] SCRATCH_IDX = SCRATCH_BASE[7:2];

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;
  localparam int CTRL_WS_LSB = 4;
  localparam int CTRL_WS_MSB = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state down-counter: loads the wait count at setup, decrements while the
// transfer is stretched and flags the final wait cycle.
module apb_wait_timer (
  input  logic       i_pclk,
  input  logic       i_presetn,
  input  logic       i_load,
  input  logic [3:0] i_ws,
  input  logic       i_dec,
  output logic       o_last
);

  logic [3:0] r_wcnt;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_wcnt <= 4'd0;
    end else if (i_load) begin
      r_wcnt <= i_ws;
    end else if (i_dec && (r_wcnt != 4'd0)) begin
      r_wcnt <= r_wcnt - 4'd1;
    end
  end

  assign o_last = (r_wcnt == 4'd1);

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer with a small register bank, programmable wait states and a
// free-running 32-bit counter with sticky overflow and level interrupt.
//
// state | meaning
// IDLE  | no transfer in flight; a setup phase loads the wait count
// WAIT  | stretching the access phase, pready held low
// DONE  | pready high while psel & penable; write commits, read data driven
module apb_completer_regs
  import apb_regs_pkg::*;
#(
  parameter int NUM_SCRATCH  = 4,
  parameter int DEFAULT_WAIT = 0
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        irq
);

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic        w_dec;
  logic        w_last;
  logic        w_pready;
  logic        w_wr;
  logic [5:0]  w_idx;
  logic        r_en;
  logic        r_ie;
  logic [3:0]  r_ws;
  logic        r_ovf;
  logic [31:0] r_count;
  logic [31:0] r_scratch [NUM_SCRATCH];
  logic [31:0] w_rdata;
  logic        w_count_wr;
  logic        w_status_w1c;
  logic        w_wrap;
  logic        w_unused;

  assign w_idx    = paddr[7:2];
  assign w_unused = ^{paddr[31:8], paddr[1:0]};

  apb_wait_timer u_timer (
    .i_pclk    (pclk),
    .i_presetn (presetn),
    .i_load    (w_load),
    .i_ws      (r_ws),
    .i_dec     (w_dec),
    .o_last    (w_last)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_pready = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_load = 1'b1;
          w_next = (r_ws == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          w_next = IDLE;
        end else begin
          w_dec = 1'b1;
          if (w_last) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        w_pready = psel && penable;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_wr = w_pready && pwrite;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_ws <= 4'(DEFAULT_WAIT);
    end else if (w_wr && (w_idx == CTRL_IDX)) begin
      r_en <= pwdata[CTRL_EN_BIT];
      r_ie <= pwdata[CTRL_IE_BIT];
      r_ws <= pwdata[CTRL_WS_MSB:CTRL_WS_LSB];
    end
  end

  // A bus write to COUNT overrides the increment, so no wrap is seen that cycle.
  assign w_count_wr   = w_wr && (w_idx == COUNT_IDX);
  assign w_wrap       = r_en && !w_count_wr && (r_count == 32'hFFFF_FFFF);
  assign w_status_w1c = w_wr && (w_idx == STATUS_IDX) && pwdata[0];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_count <= 32'd0;
    end else if (w_count_wr) begin
      r_count <= pwdata;
    end else if (r_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end else if (w_status_w1c) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        r_scratch[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_wr && (w_idx == SCRATCH_IDX + 6'(i))) begin
          r_scratch[i] <= pwdata;
        end
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      CTRL_IDX: begin
        w_rdata[CTRL_EN_BIT]             = r_en;
        w_rdata[CTRL_IE_BIT]             = r_ie;
        w_rdata[CTRL_WS_MSB:CTRL_WS_LSB] = r_ws;
      end
      STATUS_IDX: w_rdata[0] = r_ovf;
      COUNT_IDX:  w_rdata    = r_count;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (w_idx == SCRATCH_IDX + 6'(i)) begin
            w_rdata = r_scratch[i];
          end
        end
      end
    endcase
  end

  assign pready = w_pready;
  assign prdata = (w_pready && !pwrite) ? w_rdata : 32'd0;
  assign irq    = r_ovf && r_ie;

endmodule
